// File: rtl/sram_arbiter.sv
// Three-port arbiter (loader, data, instruction fetch) in front of one async SRAM.
// Ports: clk, rst (sync, active-low); if_* read port; dm_* read/write port;
//        ld_* write-only port; each requester gets a one-cycle ack.
//        ram_addr/ram_data/ram_en/ram_oe/ram_we drive the SRAM (strobes
//        active-low, shared bidirectional data bus); busy flags an access.
module sram_arbiter #(
    parameter logic [1:0]  ADDR_HI      = 2'b00,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_ack,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_wdata,
    output logic        ld_ack,
    output logic [17:0] ram_addr,
    inout  wire  [15:0] ram_data,
    output logic        ram_en,
    output logic        ram_oe,
    output logic        ram_we,
    output logic        busy
);
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] { IDLE, STROBE, HOLD } state_t;
    typedef enum logic [1:0] { G_IF, G_DM, G_LD } gnt_t;

    state_t        state;
    state_t        state_d;
    gnt_t          gnt_q;
    gnt_t          gnt_d;
    logic [15:0]   addr_q;
    logic [15:0]   addr_d;
    logic [15:0]   wdata_q;
    logic [15:0]   wdata_d;
    logic          we_q;
    logic          we_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          drv_q;
    logic          drv_d;
    logic [17:0]   ram_addr_d;
    logic          ram_en_d;
    logic          ram_oe_d;
    logic          ram_we_d;
    logic          busy_d;
    logic          if_ack_d;
    logic          dm_ack_d;
    logic          ld_ack_d;

    // Bus is driven only for writes, and writes always keep ram_oe high.
    assign ram_data = drv_q ? wdata_q : 'z;

    always_comb begin
        state_d    = state;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        drv_d      = 1'b0;
        ram_addr_d = ram_addr;
        ram_en_d   = 1'b1;
        ram_oe_d   = 1'b1;
        ram_we_d   = 1'b1;
        busy_d     = 1'b0;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        ld_ack_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!if_req)
                    cnt_d = '0;
                if (if_req || dm_req || ld_req) begin
                    // A starved fetch overrides the fixed ld > dm > if order.
                    if (if_req && cnt_q == LIM)
                        gnt_d = G_IF;
                    else if (ld_req)
                        gnt_d = G_LD;
                    else if (dm_req)
                        gnt_d = G_DM;
                    else
                        gnt_d = G_IF;
                    unique case (gnt_d)
                        G_LD: begin
                            addr_d  = ld_addr;
                            we_d    = 1'b1;
                            wdata_d = ld_wdata;
                        end
                        G_DM: begin
                            addr_d  = dm_addr;
                            we_d    = dm_we;
                            wdata_d = dm_wdata;
                        end
                        default: begin
                            addr_d = if_addr;
                            we_d   = 1'b0;
                        end
                    endcase
                    if (!if_req || gnt_d == G_IF)
                        cnt_d = '0;
                    else if (cnt_q < LIM)
                        cnt_d = cnt_q + 1'b1;
                    state_d    = STROBE;
                    ram_addr_d = {ADDR_HI, addr_d};
                    ram_en_d   = 1'b0;
                    ram_oe_d   = we_d;
                    ram_we_d   = ~we_d;
                    drv_d      = we_d;
                    busy_d     = 1'b1;
                end
            end
            STROBE: begin
                // HOLD: strobe released, address and write data kept.
                state_d    = HOLD;
                ram_addr_d = {ADDR_HI, addr_q};
                ram_en_d   = 1'b0;
                ram_oe_d   = we_q;
                drv_d      = we_q;
                busy_d     = 1'b1;
                if_ack_d   = (gnt_q == G_IF);
                dm_ack_d   = (gnt_q == G_DM);
                ld_ack_d   = (gnt_q == G_LD);
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            gnt_q    <= G_IF;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            cnt_q    <= '0;
            drv_q    <= 1'b0;
            ram_addr <= '0;
            ram_en   <= 1'b1;
            ram_oe   <= 1'b1;
            ram_we   <= 1'b1;
            busy     <= 1'b0;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            ld_ack   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            state    <= state_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            cnt_q    <= cnt_d;
            drv_q    <= drv_d;
            ram_addr <= ram_addr_d;
            ram_en   <= ram_en_d;
            ram_oe   <= ram_oe_d;
            ram_we   <= ram_we_d;
            busy     <= busy_d;
            if_ack   <= if_ack_d;
            dm_ack   <= dm_ack_d;
            ld_ack   <= ld_ack_d;
            // Read data is sampled as the strobe phase closes.
            if (state == STROBE && !we_q) begin
                if (gnt_q == G_IF)
                    if_rdata <= ram_data;
                if (gnt_q == G_DM)
                    dm_rdata <= ram_data;
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: async SRAM model, directed scenarios with literal
// expectations, and randomized traffic checked against a transaction model.
module tb_sram_arbiter;
    localparam logic [1:0] AHI = 2'b00;
    localparam int LIM = 4;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_ack;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [15:0] ld_wdata;
    logic        ld_ack;
    logic [17:0] ram_addr;
    wire  [15:0] ram_data;
    logic        ram_en;
    logic        ram_oe;
    logic        ram_we;
    logic        busy;

    int total = 0;
    int bad = 0;

    sram_arbiter #(.ADDR_HI(AHI), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .ld_req(ld_req), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_en(ram_en), .ram_oe(ram_oe), .ram_we(ram_we),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [17:0] a);
        return a[15:0] ^ 16'h5A5A ^ {a[17:16], 14'h0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Asynchronous SRAM: drives the bus while selected for read, latches
    // writes while both en and we are low at a clock edge.
    logic [15:0] sram_mem [0:262143];
    logic [15:0] sram_q;
    wire         sram_oe = !ram_en && !ram_oe && ram_we;
    assign ram_data = sram_oe ? sram_q : 16'hzzzz;

    initial begin
        sram_q = '0;
        forever begin
            @(negedge clk);
            sram_q = sram_mem[ram_addr];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!ram_en && !ram_we)
                sram_mem[ram_addr] = ram_data;
        end
    end

    // Transaction model: "age" counts cycles since a grant (0 = none in
    // flight). Expected pins follow from the grant record and its age.
    logic [15:0] ref_mem [0:65535];
    int          age;
    int          who;
    int          cnt;
    logic [15:0] m_addr;
    logic [15:0] m_wd;
    logic        m_we;
    logic [15:0] m_if_rd;
    logic [15:0] m_dm_rd;
    logic        c_rst;
    logic        c_if;
    logic        c_dm;
    logic        c_ld;
    logic        c_dwe;
    logic [15:0] c_ifa;
    logic [15:0] c_dma;
    logic [15:0] c_dmw;
    logic [15:0] c_lda;
    logic [15:0] c_ldw;

    initial begin
        age = 0;
        who = 0;
        cnt = 0;
        m_addr = '0;
        m_wd = '0;
        m_we = 1'b0;
        m_if_rd = '0;
        m_dm_rd = '0;
        forever begin
            @(posedge clk);
            c_rst = rst;
            c_if = if_req;
            c_dm = dm_req;
            c_ld = ld_req;
            c_dwe = dm_we;
            c_ifa = if_addr;
            c_dma = dm_addr;
            c_dmw = dm_wdata;
            c_lda = ld_addr;
            c_ldw = ld_wdata;
            @(negedge clk);
            // A write strobe active at the edge lands even if reset hits.
            if (age == 1 && m_we)
                ref_mem[m_addr] = m_wd;
            if (!c_rst) begin
                age = 0;
                cnt = 0;
                m_if_rd = '0;
                m_dm_rd = '0;
            end else if (age == 1) begin
                age = 2;
                if (!m_we && who == 0)
                    m_if_rd = ref_mem[m_addr];
                if (!m_we && who == 1)
                    m_dm_rd = ref_mem[m_addr];
            end else if (age == 2) begin
                age = 0;
            end else begin
                if (!c_if)
                    cnt = 0;
                if (c_if || c_dm || c_ld) begin
                    if (c_if && cnt == LIM)
                        who = 0;
                    else if (c_ld)
                        who = 2;
                    else if (c_dm)
                        who = 1;
                    else
                        who = 0;
                    m_addr = (who == 2) ? c_lda : (who == 1) ? c_dma : c_ifa;
                    m_we = (who == 2) ? 1'b1 : (who == 1) ? c_dwe : 1'b0;
                    m_wd = (who == 2) ? c_ldw : c_dmw;
                    if (!c_if || who == 0)
                        cnt = 0;
                    else
                        cnt = (cnt < LIM) ? cnt + 1 : LIM;
                    age = 1;
                end
            end
            chk("busy", 32'(busy), 32'(age != 0));
            chk("ram_en", 32'(ram_en), 32'(age == 0));
            chk("ram_we", 32'(ram_we), 32'(!(age == 1 && m_we)));
            chk("if_ack", 32'(if_ack), 32'(age == 2 && who == 0));
            chk("dm_ack", 32'(dm_ack), 32'(age == 2 && who == 1));
            chk("ld_ack", 32'(ld_ack), 32'(age == 2 && who == 2));
            chk("if_rdata", 32'(if_rdata), 32'(m_if_rd));
            chk("dm_rdata", 32'(dm_rdata), 32'(m_dm_rd));
            if (age == 0)
                chk("ram_oe_idle", 32'(ram_oe), 32'd1);
            if (age == 1)
                chk("ram_oe_strobe", 32'(ram_oe), 32'(m_we));
            if (age != 0)
                chk("ram_addr", 32'(ram_addr), 32'({AHI, m_addr}));
            if (age != 0 && m_we)
                chk("ram_data_wr", 32'(ram_data), 32'(m_wd));
            if (!c_rst)
                chk("ram_addr_rst", 32'(ram_addr), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 1) == 1)
            return 16'($urandom_range(0, 31));
        return 16'($urandom);
    endfunction

    int          t_ld;
    int          t_dm;
    int          t_if;
    int          n;
    logic [5:0]  order;
    logic        got;
    int          w_if;
    int          w_dm;
    int          w_ld;

    initial begin
        for (int i = 0; i < 262144; i++)
            sram_mem[i] = init_val(18'(i));
        for (int i = 0; i < 65536; i++)
            ref_mem[i] = init_val({AHI, 16'(i)});
        sram_mem[18'h00040] = 16'h1234;
        ref_mem[16'h0040] = 16'h1234;
        rst = 1'b0;
        if_req = 1'b0;
        if_addr = '0;
        dm_req = 1'b0;
        dm_we = 1'b0;
        dm_addr = '0;
        dm_wdata = '0;
        ld_req = 1'b0;
        ld_addr = '0;
        ld_wdata = '0;
        repeat (3) tick();
        chk("rst_en", 32'(ram_en), 32'd1);
        chk("rst_oe", 32'(ram_oe), 32'd1);
        chk("rst_we", 32'(ram_we), 32'd1);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({if_ack, dm_ack, ld_ack}), 32'd0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 32'd0);
        rst = 1'b1;
        tick();

        // Single fetch read.
        if_req = 1'b1;
        if_addr = 16'h0040;
        tick();
        chk("if_strobe_addr", 32'(ram_addr), 32'h00040);
        chk("if_strobe_oe", 32'(ram_oe), 32'd0);
        chk("if_strobe_en", 32'(ram_en), 32'd0);
        chk("if_no_early_ack", 32'(if_ack), 32'd0);
        tick();
        chk("if_ack_k2", 32'(if_ack), 32'd1);
        chk("if_rdata_val", 32'(if_rdata), 32'h1234);
        if_req = 1'b0;
        tick();
        chk("if_ack_once", 32'(if_ack), 32'd0);
        chk("if_back_idle", 32'(busy), 32'd0);

        // Data-port write.
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 16'h8001;
        dm_wdata = 16'hBEEF;
        tick();
        chk("dmw_we_strobe", 32'(ram_we), 32'd0);
        chk("dmw_data_strobe", 32'(ram_data), 32'hBEEF);
        tick();
        chk("dmw_we_hold", 32'(ram_we), 32'd1);
        chk("dmw_data_hold", 32'(ram_data), 32'hBEEF);
        chk("dmw_ack", 32'(dm_ack), 32'd1);
        chk("dmw_rdata_kept", 32'(dm_rdata), 32'h0000);
        dm_req = 1'b0;
        tick();
        chk("dmw_ack_once", 32'(dm_ack), 32'd0);

        // All three at once: ld, dm, if order.
        ld_req = 1'b1;
        ld_addr = 16'h0100;
        ld_wdata = 16'h1111;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 16'h0100;
        if_req = 1'b1;
        if_addr = 16'h8001;
        t_ld = 0;
        t_dm = 0;
        t_if = 0;
        for (int t = 1; t <= 9; t++) begin
            tick();
            if (ld_ack) begin
                t_ld = t;
                ld_req = 1'b0;
            end
            if (dm_ack) begin
                t_dm = t;
                dm_req = 1'b0;
            end
            if (if_ack) begin
                t_if = t;
                if_req = 1'b0;
            end
        end
        chk("order_ld", 32'(t_ld), 32'd2);
        chk("order_dm", 32'(t_dm), 32'd5);
        chk("order_if", 32'(t_if), 32'd8);
        chk("order_dm_rd", 32'(dm_rdata), 32'h1111);
        chk("order_if_rd", 32'(if_rdata), 32'hBEEF);

        // Continuous dm traffic must let a waiting fetch in after 4 grants.
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 16'h0040;
        if_req = 1'b1;
        if_addr = 16'h0100;
        n = 0;
        order = '0;
        for (int t = 0; t < 30 && n < 6; t++) begin
            tick();
            if (dm_ack) begin
                order[n] = 1'b1;
                n++;
            end
            if (if_ack) begin
                n++;
                if_req = 1'b0;
            end
        end
        dm_req = 1'b0;
        tick();
        chk("starve_count", 32'(n), 32'd6);
        chk("starve_order", 32'(order), 32'b101111);
        chk("starve_dm_rd", 32'(dm_rdata), 32'h1234);
        chk("starve_if_rd", 32'(if_rdata), 32'h1111);

        // Reset during a write strobe, request held across reset.
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 16'h0077;
        dm_wdata = 16'hCAFE;
        tick();
        chk("rstw_strobe_we", 32'(ram_we), 32'd0);
        rst = 1'b0;
        tick();
        chk("rstw_we", 32'(ram_we), 32'd1);
        chk("rstw_no_ack", 32'(dm_ack), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 10 && !got; t++) begin
            tick();
            if (dm_ack) begin
                got = 1'b1;
                chk("rstw_hold_data", 32'(ram_data), 32'hCAFE);
                dm_req = 1'b0;
            end
        end
        chk("rstw_done", 32'(got), 32'd1);
        tick();
        dm_req = 1'b1;
        dm_we = 1'b0;
        tick();
        tick();
        chk("rstw_readback", 32'(dm_rdata), 32'hCAFE);
        dm_req = 1'b0;
        tick();

        // Random traffic with occasional resets.
        w_if = 0;
        w_dm = 0;
        w_ld = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!rst)
                rst = 1'b1;
            else if ($urandom_range(0, 299) == 0)
                rst = 1'b0;
            if (if_ack) begin
                if_req = ($urandom_range(0, 2) == 0);
                if_addr = rand_addr();
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1;
                if_addr = rand_addr();
            end
            if (dm_ack) begin
                dm_req = ($urandom_range(0, 2) == 0);
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = rand_addr();
                dm_wdata = 16'($urandom);
            end else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1;
                dm_we = 1'($urandom_range(0, 1));
                dm_addr = rand_addr();
                dm_wdata = 16'($urandom);
            end
            if (ld_ack) begin
                ld_req = ($urandom_range(0, 2) == 0);
                ld_addr = rand_addr();
                ld_wdata = 16'($urandom);
            end else if (!ld_req && $urandom_range(0, 3) == 0) begin
                ld_req = 1'b1;
                ld_addr = rand_addr();
                ld_wdata = 16'($urandom);
            end
            w_if = (if_req && !if_ack) ? w_if + 1 : 0;
            w_dm = (dm_req && !dm_ack) ? w_dm + 1 : 0;
            w_ld = (ld_req && !ld_ack) ? w_ld + 1 : 0;
            if (w_if > 300 || w_dm > 300 || w_ld > 300) begin
                total++;
                bad++;
                $display("FAIL wait_bound: waits if=%0d dm=%0d ld=%0d limit=300",
                         w_if, w_dm, w_ld);
                w_if = 0;
                w_dm = 0;
                w_ld = 0;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        ld_req = 1'b0;
        rst = 1'b1;
        repeat (6) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
